uart_frame_tx: RTL and testbench

//  8-bit UART transmitter: counterpart of the board's UART receive path, drives the txd pin.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_frame_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_frame_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and baud divider helper.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_t;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// full and level are registered so wr_ready can come straight from a flop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [UART_DATA_W-1:0]   wr_data,
  input  logic                     rd_en,
  output logic [UART_DATA_W-1:0]   rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          level_nxt;
  logic                   wr_acc;
  logic                   rd_acc;

  assign empty   = (level == '0);
  assign wr_acc  = wr_en && !full;
  assign rd_acc  = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level + LW'(wr_acc) - LW'(rd_acc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
    end
  end

  // Storage carries no reset; only the pointers and counters define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_frame_tx.sv
// 8-bit UART transmitter: FIFO-buffered, own baud divider, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [UART_DATA_W-1:0]   wr_data,
  output logic                     wr_ready,
  output logic                     txd,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int BCW = $clog2(DIV);

  uart_state_t            state, state_nxt;
  logic [BCW-1:0]         baud_cnt, baud_nxt;
  logic [2:0]             bit_cnt, bit_nxt;
  logic                   txd_nxt, busy_nxt, done_nxt;
  logic                   pop, shift_en;
  logic                   baud_end;
  logic [UART_DATA_W-1:0] shift;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   fifo_full, fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                   par_bit;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign wr_ready = !fifo_full;
  assign baud_end = (baud_cnt == BCW'(DIV - 1));

  // Next-state and next-output logic; txd/busy/done are then registered.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + BCW'(1);
    bit_nxt   = bit_cnt;
    txd_nxt   = txd;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
          bit_nxt   = '0;
          txd_nxt   = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = DATA;
          txd_nxt   = shift[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) begin
            bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            txd_nxt   = par_bit;
`else
            state_nxt = STOP;
            txd_nxt   = 1'b1;
`endif
          end else begin
            bit_nxt  = bit_cnt + 3'd1;
            shift_en = 1'b1;
            txd_nxt  = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = STOP;
          txd_nxt   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            bit_nxt  = '0;
            done_nxt = 1'b1;
            // Chain straight into the next frame when another byte is waiting.
            if (!fifo_empty) begin
              pop       = 1'b1;
              state_nxt = START;
              txd_nxt   = 1'b0;
            end else begin
              state_nxt = IDLE;
              txd_nxt   = 1'b1;
              busy_nxt  = 1'b0;
            end
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      txd      <= txd_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Datapath: shift register loads on pop, parity is captured with it.
  always_ff @(posedge clk) begin
    if (pop)           shift <= fifo_dout;
    else if (shift_en) shift <= {1'b0, shift[UART_DATA_W-1:1]};
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (pop) par_bit <= ^fifo_dout;
  end
`endif

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx at CLK_FREQ=1000, BAUD=100 (DIV=10), DEPTH=4.
// dut0 uses one stop bit, dut1 uses two; both share clock and reset.
module tb_uart_frame_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DIV      = 10;
  localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en0 = 1'b0, wr_en1 = 1'b0;
  logic [7:0] wr_data0 = '0, wr_data1 = '0;
  logic       wr_ready0, wr_ready1, txd0, txd1, busy0, busy1, done0, done1;
  logic [2:0] level0, level1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_frame_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_data(wr_data0), .wr_ready(wr_ready0),
    .txd(txd0), .busy(busy0), .done(done0), .level(level0)
  );

  uart_frame_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_data(wr_data1), .wr_ready(wr_ready1),
    .txd(txd1), .busy(busy1), .done(done1), .level(level1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Called in the first start-bit cycle; returns in the cycle after the last stop cycle.
  task automatic check_frame(input logic [7:0] b, input bit sel);
    logic [15:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    nb = 9;
`ifdef UART_TX_PARITY_EN
    bits[9] = ^b;
`endif
    nb = nb + PBITS + (sel ? 2 : 1);
    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < DIV; k++) begin
        check($sformatf("txd%0d byte %0h bit %0d cyc %0d", sel, b, i, k),
              sel ? txd1 : txd0, bits[i]);
        check($sformatf("busy%0d byte %0h", sel, b), sel ? busy1 : busy0, 1);
        if (i != 0 || k != 0)
          check($sformatf("done%0d early byte %0h", sel, b), sel ? done1 : done0, 0);
        tick;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int cnt;
    repeat (2) tick;
    check("rst txd",      txd0, 1);
    check("rst busy",     busy0, 0);
    check("rst done",     done0, 0);
    check("rst wr_ready", wr_ready0, 1);
    check("rst level",    level0, 0);
    check("rst txd1",     txd1, 1);
    reset = 1'b1;
    tick;

    // Single byte with cycle-exact latency.
    wr_data0 = 8'h55; wr_en0 = 1'b1; tick;
    wr_en0 = 1'b0;
    check("t1 level", level0, 1);
    check("t1 txd idle", txd0, 1);
    check("t1 busy idle", busy0, 0);
    tick;
    check_frame(8'h55, 1'b0);
    check("t1 done", done0, 1);
    check("t1 busy after", busy0, 0);
    check("t1 txd after", txd0, 1);
    check("t1 level after", level0, 0);
    tick;
    check("t1 done single", done0, 0);

    // Back-to-back frames.
    wr_data0 = 8'hA3; wr_en0 = 1'b1; tick;
    wr_data0 = 8'h0F;
    check("t2 level n1", level0, 1);
    tick;
    wr_en0 = 1'b0;
    check("t2 level n2", level0, 1);
    check_frame(8'hA3, 1'b0);
    check("t2 done1", done0, 1);
    check("t2 busy gap", busy0, 1);
    check_frame(8'h0F, 1'b0);
    check("t2 done2", done0, 1);
    check("t2 busy end", busy0, 0);
    tick;

    // Overflow on a 4-deep FIFO while the first frame is in flight.
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          wr_data0 = 8'(i); wr_en0 = 1'b1;
          if (i == 1) check("t3 ready first", wr_ready0, 1);
          if (i == 5) check("t3 ready before full", wr_ready0, 1);
          if (i == 6) begin
            check("t3 ready full", wr_ready0, 0);
            check("t3 level full", level0, 4);
          end
          tick;
        end
        wr_en0 = 1'b0;
        check("t3 level after drop", level0, 4);
      end
      begin
        repeat (2) tick;
        for (int b = 1; b <= 5; b++) begin
          check_frame(8'(b), 1'b0);
          check($sformatf("t3 done %0d", b), done0, 1);
        end
        check("t3 busy end", busy0, 0);
        check("t3 level end", level0, 0);
      end
    join
    cnt = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      if (txd0 !== 1'b1 || busy0 !== 1'b0) cnt++;
      tick;
    end
    check("t3 no sixth frame", cnt, 0);

    // Reset during the start bit must raise txd without a clock edge.
    wr_data0 = 8'h00; wr_en0 = 1'b1; tick;
    wr_en0 = 1'b0; tick;
    repeat (5) tick;
    check("t4a txd low", txd0, 0);
    reset = 1'b0; #1;
    check("t4a txd async", txd0, 1);
    check("t4a busy", busy0, 0);
    tick;
    reset = 1'b1;
    tick;

    // Reset during data bit 3 of 8'hFF.
    wr_data0 = 8'hFF; wr_en0 = 1'b1; tick;
    wr_en0 = 1'b0; tick;
    repeat (45) tick;
    check("t4 busy mid", busy0, 1);
    reset = 1'b0; #1;
    check("t4 txd async", txd0, 1);
    check("t4 level", level0, 0);
    check("t4 busy", busy0, 0);
    check("t4 ready", wr_ready0, 1);
    tick;
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12 * DIV; i++) begin
      tick;
      if (done0 !== 1'b0 || txd0 !== 1'b1) cnt++;
    end
    check("t4 quiet after reset", cnt, 0);
    wr_data0 = 8'h3C; wr_en0 = 1'b1; tick;
    wr_en0 = 1'b0; tick;
    check_frame(8'h3C, 1'b0);
    check("t4 done clean", done0, 1);
    tick;

    // Parity-sensitive bytes (parity bit checked when the feature is built in).
    wr_data0 = 8'h07; wr_en0 = 1'b1; tick;
    wr_en0 = 1'b0; tick;
    check_frame(8'h07, 1'b0);
    check("t5 done 07", done0, 1);
    tick;
    wr_data0 = 8'h03; wr_en0 = 1'b1; tick;
    wr_en0 = 1'b0; tick;
    check_frame(8'h03, 1'b0);
    check("t5 done 03", done0, 1);
    tick;

    // Two stop bits.
    wr_data1 = 8'h00; wr_en1 = 1'b1; tick;
    wr_en1 = 1'b0; tick;
    check_frame(8'h00, 1'b1);
    check("t6 done", done1, 1);
    check("t6 busy", busy1, 0);
    tick;
    check("t6 done single", done1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
